text_ram_arbiter: RTL and testbench

TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

---
 rtl/text_ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_text_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_ram_arbiter.sv
// Text RAM arbiter: display character fetches pre-empt queued host writes to one synchronous RAM port.
// Latency: fetch strobe -> char_valid 4 edges later; a queued write reaches the RAM port 1 edge after it is popped.
// Backpressure: host_ready drops while the write FIFO is full or in reset; fetches are never stalled.
//
// Ports:
//   clk, reset                  system clock, asynchronous active-low reset
//   clk_load_char, xtext, ytext display fetch strobe and text cell coordinates
//   host_valid/ready/addr/data  host write request (valid/ready handshake into the FIFO)
//   ram_addr/wdata/we, ram_rdata registered RAM port, read data one cycle after the address
//   char_data, char_valid       fetched character word and its one-cycle strobe
//   addr_error                  one-cycle pulse when a popped host write is out of range
module text_ram_arbiter #(
  parameter int TEXT_COLS  = 100,
  parameter int TEXT_ROWS  = 60,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_load_char,
  input  logic [6:0]            xtext,
  input  logic [5:0]            ytext,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] char_data,
  output logic                  char_valid,
  output logic                  addr_error
);

  localparam int          PTR_W      = $clog2(FIFO_DEPTH);
  localparam int          CNT_W      = PTR_W + 1;
  localparam logic [31:0] TEXT_CELLS = 32'(TEXT_COLS * TEXT_ROWS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dat;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_ADDR,
    FETCH_WAIT,
    FETCH_CAPTURE
  } state_t;

  state_t                state_q, state_d;
  wr_entry_t             fifo_mem_q [FIFO_DEPTH];
  wr_entry_t             fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  rdy_en_q, rdy_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic [DATA_WIDTH-1:0] char_data_q, char_data_d;
  logic                  char_valid_q, char_valid_d;
  logic                  addr_error_q, addr_error_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  wr_entry_t             head;
  logic                  head_oob;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  // rdy_en_q keeps host_ready low through reset and lets it rise on the first edge after release.
  assign host_ready = rdy_en_q && (count_q < CNT_W'(FIFO_DEPTH));
  assign fifo_push  = host_valid && host_ready;
  assign head       = fifo_mem_q[rd_ptr_q];
  assign head_oob   = (32'(head.addr) >= TEXT_CELLS);
  assign fetch_addr = ADDR_WIDTH'(ytext) * ADDR_WIDTH'(TEXT_COLS) + ADDR_WIDTH'(xtext);

  // Arbitration FSM. A strobe in IDLE always wins; writes only drain in IDLE cycles without a strobe.
  always_comb begin
    state_d      = state_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 1'b0;
    char_data_d  = char_data_q;
    char_valid_d = 1'b0;
    addr_error_d = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clk_load_char) begin
          state_d    = FETCH_ADDR;
          ram_addr_d = fetch_addr;
        end else if (count_q != '0) begin
          fifo_pop = 1'b1;
          if (head_oob) begin
            addr_error_d = 1'b1;
          end else begin
            ram_we_d    = 1'b1;
            ram_addr_d  = head.addr;
            ram_wdata_d = head.dat;
          end
        end
      end
      // ram_addr is held through the fetch so the RAM keeps returning the same word.
      FETCH_ADDR: state_d = FETCH_WAIT;
      FETCH_WAIT: state_d = FETCH_CAPTURE;
      FETCH_CAPTURE: begin
        char_data_d  = ram_rdata;
        char_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write FIFO: power-of-two depth so pointers wrap naturally; the count decides full/empty.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rdy_en_d   = 1'b1;
    if (fifo_push) begin
      fifo_mem_d[wr_ptr_q] = '{addr: host_addr, dat: host_data};
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fifo_mem_q   <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rdy_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      char_data_q  <= '0;
      char_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_mem_q   <= fifo_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rdy_en_q     <= rdy_en_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign addr_error = addr_error_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a behavioural synchronous RAM.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every comparison is an immediate assertion that counts its own failure.
module tb_text_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_load_char;
  logic [6:0]  xtext;
  logic [5:0]  ytext;
  logic        host_valid;
  logic        host_ready;
  logic [12:0] host_addr;
  logic [15:0] host_data;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [15:0] char_data;
  logic        char_valid;
  logic        addr_error;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_cv;
  int   seq, wr_idx, win_w, we_cnt, cv_cnt;

  always #5 clk = ~clk;

  text_ram_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .clk_load_char (clk_load_char),
    .xtext         (xtext),
    .ytext         (ytext),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_we        (ram_we),
    .ram_rdata     (ram_rdata),
    .char_data     (char_data),
    .char_valid    (char_valid),
    .addr_error    (addr_error)
  );

  // Initial RAM contents: a fixed pattern, with the character word used by the first fetch.
  function automatic logic [15:0] init_val(input int a);
    if (a == 205) return 16'h1A41;
    return 16'(a) ^ 16'hC300;
  endfunction

  // Synchronous RAM model: cells never written return init_val.
  logic [15:0] mem    [0:8191];
  bit          wr_vld [0:8191];
  always @(posedge clk) begin
    ram_rdata <= wr_vld[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
    if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      wr_vld[ram_addr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    clk_load_char = 1'b0;
    xtext         = '0;
    ytext         = '0;
    host_valid    = 1'b0;
    host_addr     = '0;
    host_data     = '0;
    #2 reset = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_host_ready", host_ready, 0);
    check("rst_ram_we",     ram_we,     0);
    check("rst_ram_addr",   ram_addr,   0);
    check("rst_ram_wdata",  ram_wdata,  0);
    check("rst_char_data",  char_data,  0);
    check("rst_char_valid", char_valid, 0);
    check("rst_addr_error", addr_error, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready_rise", host_ready, 1);

    // ---- T1: single fetch x=5 y=2 ----
    clk_load_char = 1'b1; xtext = 7'd5; ytext = 6'd2;
    @(negedge clk);
    clk_load_char = 1'b0;
    check("t1_ram_addr", ram_addr, 205);
    check("t1_ram_we",   ram_we,   0);
    @(negedge clk);
    check("t1_cv_early1", char_valid, 0);
    @(negedge clk);
    check("t1_cv_early2", char_valid, 0);
    @(negedge clk);
    check("t1_cv",    char_valid, 1);
    check("t1_cdata", char_data,  32'h1A41);
    @(negedge clk);
    check("t1_cv_end", char_valid, 0);

    // ---- T2: fill FIFO during a fetch, then drain in order ----
    clk_load_char = 1'b1; xtext = 7'd0; ytext = 6'd0;
    host_valid = 1'b1; host_addr = 13'd10; host_data = 16'h1111;
    @(negedge clk);
    check("t2_fetch_addr", ram_addr, 0);
    check("t2_fetch_we",   ram_we,   0);
    clk_load_char = 1'b0; host_addr = 13'd11; host_data = 16'h2222;
    @(negedge clk);
    host_addr = 13'd12; host_data = 16'h3333;
    @(negedge clk);
    check("t2_ready_3", host_ready, 1);
    host_addr = 13'd13; host_data = 16'h4444;
    @(negedge clk);
    check("t2_ready_full", host_ready, 0);
    check("t2_cv",         char_valid, 1);
    check("t2_cdata",      char_data,  32'hC300);
    check("t2_we_capture", ram_we,     0);
    // Offered while full: must not be accepted even though a pop happens this cycle.
    host_addr = 13'd14; host_data = 16'h5555;
    @(negedge clk);
    host_valid = 1'b0;
    check("t2_w0_we",    ram_we,     1);
    check("t2_w0_addr",  ram_addr,   10);
    check("t2_w0_data",  ram_wdata,  32'h1111);
    check("t2_ready_up", host_ready, 1);
    @(negedge clk);
    check("t2_w1_we",   ram_we,    1);
    check("t2_w1_addr", ram_addr,  11);
    check("t2_w1_data", ram_wdata, 32'h2222);
    @(negedge clk);
    check("t2_w2_addr", ram_addr,  12);
    check("t2_w2_data", ram_wdata, 32'h3333);
    @(negedge clk);
    check("t2_w3_addr", ram_addr,  13);
    check("t2_w3_data", ram_wdata, 32'h4444);
    @(negedge clk);
    check("t2_no_extra_we", ram_we, 0);

    // ---- T3: one queued write vs strobe: fetch first ----
    host_valid = 1'b1; host_addr = 13'd300; host_data = 16'hBEEF;
    @(negedge clk);
    host_valid = 1'b0;
    clk_load_char = 1'b1; xtext = 7'd7; ytext = 6'd3;
    @(negedge clk);
    clk_load_char = 1'b0;
    check("t3_fetch_addr", ram_addr, 307);
    check("t3_fetch_we",   ram_we,   0);
    @(negedge clk);
    check("t3_we_wait", ram_we, 0);
    @(negedge clk);
    check("t3_we_capture", ram_we, 0);
    @(negedge clk);
    check("t3_cv",    char_valid, 1);
    check("t3_cdata", char_data,  32'(init_val(307)));
    check("t3_we_cv", ram_we,     0);
    @(negedge clk);
    check("t3_w_we",   ram_we,     1);
    check("t3_w_addr", ram_addr,   300);
    check("t3_w_data", ram_wdata,  32'hBEEF);
    check("t3_cv_end", char_valid, 0);

    // ---- T4: out-of-range write dropped, next write proceeds ----
    host_valid = 1'b1; host_addr = 13'd6000; host_data = 16'h0BAD;
    @(negedge clk);
    host_addr = 13'd5999; host_data = 16'h7777;
    @(negedge clk);
    host_valid = 1'b0;
    check("t4_err",    addr_error, 1);
    check("t4_err_we", ram_we,     0);
    @(negedge clk);
    check("t4_ok_we",   ram_we,     1);
    check("t4_ok_addr", ram_addr,   5999);
    check("t4_ok_data", ram_wdata,  32'h7777);
    check("t4_err_end", addr_error, 0);
    @(negedge clk);
    check("t4_idle_we", ram_we, 0);

    // ---- T5: strobe every 8 cycles with continuous host traffic ----
    seq = 0; wr_idx = 0; win_w = 0;
    for (int c = 0; c < 48; c++) begin
      if (ram_we === 1'b1) begin
        check($sformatf("t5_waddr%0d", wr_idx), 32'(ram_addr),  32'(1000 + wr_idx));
        check($sformatf("t5_wdata%0d", wr_idx), 32'(ram_wdata), 32'(32'hA000 + wr_idx));
        wr_idx++;
        if (c >= 9 && c <= 40) win_w++;
      end
      exp_cv = ((c % 8) == 4) && (c <= 36);
      check($sformatf("t5_cv_c%0d", c), char_valid, exp_cv);
      if (exp_cv) check($sformatf("t5_cdata_c%0d", c), char_data, 32'(init_val(100 + (c - 4) / 8)));
      host_valid = (c < 40);
      host_addr  = 13'(1000 + seq);
      host_data  = 16'(32'hA000 + seq);
      if (host_valid && host_ready) seq++;
      clk_load_char = ((c % 8) == 0) && (c < 40);
      xtext = 7'(c / 8);
      ytext = 6'd1;
      @(negedge clk);
    end
    check("t5_all_written", wr_idx, seq);
    check("t5_writes_per_window", win_w, 16);

    // ---- T6: reset in FETCH_WAIT with 3 queued writes ----
    host_valid = 1'b1; host_addr = 13'd2000; host_data = 16'h0001;
    @(negedge clk);
    clk_load_char = 1'b1; xtext = 7'd0; ytext = 6'd0;
    host_addr = 13'd2001; host_data = 16'h0002;
    @(negedge clk);
    clk_load_char = 1'b0;
    host_addr = 13'd2002; host_data = 16'h0003;
    @(negedge clk);
    host_valid = 1'b0;
    check("t6_ready_pre", host_ready, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_host_ready", host_ready, 0);
    check("t6_ram_we",     ram_we,     0);
    check("t6_ram_addr",   ram_addr,   0);
    check("t6_ram_wdata",  ram_wdata,  0);
    check("t6_char_data",  char_data,  0);
    check("t6_char_valid", char_valid, 0);
    check("t6_addr_error", addr_error, 0);
    @(negedge clk);
    reset = 1'b1;
    we_cnt = 0; cv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("t6_ready_rise", host_ready, 1);
      if (ram_we === 1'b1) we_cnt++;
      if (char_valid === 1'b1) cv_cnt++;
    end
    check("t6_no_writes", we_cnt, 0);
    check("t6_no_cv",     cv_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
